// File: rtl/wb_guard_pkg.sv
// ---------------------------------------------------------------------------
// wb_guard_pkg
//   Shared types and defaults for the Wishbone timeout guard.
//   guard_state_t : FSM state encoding of the guard
//   WB_ERR_DATA   : default read word returned for a timed-out cycle
// ---------------------------------------------------------------------------
package wb_guard_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    TO_ACK  = 2'd2,
    RECOVER = 2'd3
  } guard_state_t;

  localparam logic [31:0] WB_ERR_DATA = 32'hDEAD_BEEF;

  // Saturating increment used by the status counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
    return (val >= max) ? max : val + 32'd1;
  endfunction

endpackage

// File: rtl/wb_timeout_guard_if.sv
// ---------------------------------------------------------------------------
// wb_timeout_guard_if
//   Bus signals seen by the timeout guard: the upstream Wishbone master side
//   (cyc/stb/adr in, ack/dat out) and the downstream interconnect side
//   (stb out, ack/dat in).
//   slave  : view of the guard itself
//   master : view of whatever drives the guard (CPU + interconnect, or a bench)
// ---------------------------------------------------------------------------
interface wb_timeout_guard_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        ic_stb_o;
  logic        ic_ack_i;
  logic [31:0] ic_dat_i;

  modport slave (
    input  wbs_cyc_i,
    input  wbs_stb_i,
    input  wbs_adr_i,
    output wbs_ack_o,
    output wbs_dat_o,
    output ic_stb_o,
    input  ic_ack_i,
    input  ic_dat_i
  );

  modport master (
    output wbs_cyc_i,
    output wbs_stb_i,
    output wbs_adr_i,
    input  wbs_ack_o,
    input  wbs_dat_o,
    input  ic_stb_o,
    output ic_ack_i,
    output ic_dat_i
  );

endinterface

// File: rtl/wb_timeout_guard.sv
// ---------------------------------------------------------------------------
// wb_timeout_guard
//   Wishbone watchdog between the management-core master and the
//   interconnect. Strobes are forwarded downstream and acks/data returned
//   with zero added latency. If no ack arrives within TIMEOUT_CYCLES the
//   guard acks the master itself with ERR_DATA, counts the event and
//   remembers the faulting address.
//
//   Ports
//     wb_clk_i        bus clock
//     wb_rst_i        synchronous active-high reset
//     bus             upstream/downstream bus signals (slave modport)
//     timeout_clr_i   pulse: clears timeout_count_o and last_to_adr_o
//     timeout_count_o saturating count of timed-out cycles
//     last_to_adr_o   address of the most recent timed-out cycle
//     timeout_irq_o   one-cycle pulse when a timeout ack is issued
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | no cycle outstanding; a new req is forwarded immediately
//   WAIT    | req forwarded, waiting for the slave ack, counting cycles
//   TO_ACK  | single cycle: error ack to the master, status update
//   RECOVER | cycle terminated; wait for the master to drop req
// ---------------------------------------------------------------------------
module wb_timeout_guard
  import wb_guard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = WB_ERR_DATA,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_timeout_guard_if.slave   bus,
  input  logic                timeout_clr_i,
  output logic [CNT_W-1:0]    timeout_count_o,
  output logic [31:0]         last_to_adr_o,
  output logic                timeout_irq_o
);

  localparam int unsigned       WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  guard_state_t      state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
  logic [31:0]       last_adr_q, last_adr_d;

  logic              req;
  logic              ic_stb;
  logic              wbs_ack;
  logic [31:0]       wbs_dat;
  logic              irq;

  assign req = bus.wbs_cyc_i & bus.wbs_stb_i;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    to_cnt_d   = to_cnt_q;
    last_adr_d = last_adr_q;
    ic_stb     = 1'b0;
    wbs_ack    = 1'b0;
    wbs_dat    = '0;
    irq        = 1'b0;

    unique case (state_q)
      IDLE: begin
        ic_stb  = req;
        wbs_ack = req & bus.ic_ack_i;
        wbs_dat = req ? bus.ic_dat_i : '0;
        // A zero-wait slave completes here without ever entering WAIT.
        if (req && !bus.ic_ack_i) begin
          state_d    = WAIT;
          wait_cnt_d = WAIT_ONE;
        end
      end

      WAIT: begin
        ic_stb  = req;
        wbs_ack = req & bus.ic_ack_i;
        wbs_dat = req ? bus.ic_dat_i : '0;
        // A real ack is tested before expiry so it wins a same-cycle race.
        if (bus.ic_ack_i || !req) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = TO_ACK;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      TO_ACK: begin
        wbs_ack    = 1'b1;
        wbs_dat    = ERR_DATA;
        irq        = 1'b1;
        last_adr_d = bus.wbs_adr_i;
        to_cnt_d   = CNT_W'(sat_inc(32'(to_cnt_q), 32'(CNT_MAX)));
        state_d    = RECOVER;
      end

      RECOVER: begin
        // Late slave acks are swallowed; a held req is not re-issued.
        if (!req) begin
          state_d = IDLE;
        end
      end
    endcase

    // Firmware clear has priority over a same-cycle timeout update.
    if (timeout_clr_i) begin
      to_cnt_d   = '0;
      last_adr_d = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      to_cnt_q   <= '0;
      last_adr_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      to_cnt_q   <= to_cnt_d;
      last_adr_q <= last_adr_d;
    end
  end

  assign bus.ic_stb_o    = ic_stb;
  assign bus.wbs_ack_o   = wbs_ack;
  assign bus.wbs_dat_o   = wbs_dat;
  assign timeout_irq_o   = irq;
  assign timeout_count_o = to_cnt_q;
  assign last_to_adr_o   = last_adr_q;

endmodule
